// File: rtl/wb_arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_2m1s
// Brief    : Two-master / one-slave Wishbone classic arbiter with round-robin
//            tie breaking, cycle locking and a stalled-strobe watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_2m1s #(
    parameter int BUS_WIDTH = 32,
    parameter int BUS_MASK  = 4,
    parameter int TO_W      = 8,
    parameter int TO_CYCLES = 200
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // master 0
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [BUS_WIDTH-1:0] m0_adr_i,
    input  logic [BUS_WIDTH-1:0] m0_dat_i,
    input  logic [BUS_MASK-1:0]  m0_sel_i,
    output logic [BUS_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    // master 1
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [BUS_WIDTH-1:0] m1_adr_i,
    input  logic [BUS_WIDTH-1:0] m1_dat_i,
    input  logic [BUS_MASK-1:0]  m1_sel_i,
    output logic [BUS_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    // slave
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [BUS_WIDTH-1:0] s_adr_o,
    output logic [BUS_WIDTH-1:0] s_dat_o,
    output logic [BUS_MASK-1:0]  s_sel_o,
    input  logic [BUS_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    // status
    output logic [1:0]           gnt_o,
    output logic                 to_evt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TO_CYCLES - 1);
    localparam logic [TO_W-1:0] C_TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_last_gnt;   // 0: m0 held the bus last, 1: m1 did
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_stb_kill;   // hides the strobe for one cycle after a timeout

    logic              w_g0;
    logic              w_g1;
    logic              w_stall;
    logic              w_fire;

    assign w_g0  = (r_state == ST_G0);
    assign w_g1  = (r_state == ST_G1);
    assign gnt_o = {w_g1, w_g0};

    // Route the granted master's request onto the slave port.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (w_g0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~r_stb_kill;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (w_g1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~r_stb_kill;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // A real slave termination in the last allowed cycle beats the watchdog.
    assign w_stall  = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
    assign w_fire   = w_stall & (r_to_cnt == C_TO_LAST);
    assign to_evt_o = w_fire;

    // Return the slave response (plus any watchdog error) to the granted master only.
    always_comb begin
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_g0) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | w_fire;
        end else if (w_g1) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | w_fire;
        end
    end

    // Grant state machine, round-robin history and watchdog counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_to_cnt   <= '0;
            r_stb_kill <= 1'b0;
        end else begin
            r_stb_kill <= w_fire;
            r_to_cnt   <= (w_stall && !w_fire) ? r_to_cnt + C_TO_ONE : '0;
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        r_state <= r_last_gnt ? ST_G0 : ST_G1;
                    end else if (m0_cyc_i) begin
                        r_state <= ST_G0;
                    end else if (m1_cyc_i) begin
                        r_state <= ST_G1;
                    end
                end
                ST_G0: begin
                    if (!m0_cyc_i) begin
                        r_state    <= ST_IDLE;
                        r_last_gnt <= 1'b0;
                    end
                end
                ST_G1: begin
                    if (!m1_cyc_i) begin
                        r_state    <= ST_IDLE;
                        r_last_gnt <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb_2m1s.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arb_2m1s
// Brief    : Self-checking bench for wb_arb_2m1s: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural ownership/stall model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arb_2m1s;

    localparam int C_TO = 200;

    logic        clk;
    logic        rst;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] mdat [2];
    logic        mack [2];
    logic        merr [2];
    logic [31:0] s_dat;
    logic        s_ack;
    logic        s_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;
    logic        to_evt;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    // model: who owns the bus (-1 none), who owned it last, stalled-run length
    int mo;
    int ml;
    int mrun;
    bit mkill;

    wb_arb_2m1s #(.BUS_WIDTH(32), .BUS_MASK(4), .TO_W(8), .TO_CYCLES(C_TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]),
        .m0_dat_o(mdat[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]),
        .m1_dat_o(mdat[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt), .to_evt_o(to_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit stalled();
        if (mo < 0) return 1'b0;
        return cyc[mo] && stb[mo] && !mkill && !s_ack && !s_err;
    endfunction

    function automatic bit fires();
        return stalled() && (mrun == C_TO - 1);
    endfunction

    // Advance the behavioural model on each rising edge.
    always @(posedge clk) begin
        bit f;
        bit st;
        if (rst) begin
            mo = -1; ml = 1; mrun = 0; mkill = 0;
        end else begin
            f  = fires();
            st = stalled();
            mkill = f;
            mrun  = (st && !f) ? mrun + 1 : 0;
            if (mo < 0) begin
                if (cyc[0] && cyc[1]) mo = 1 - ml;
                else if (cyc[0])      mo = 0;
                else if (cyc[1])      mo = 1;
            end else if (!cyc[mo]) begin
                ml = mo;
                mo = -1;
            end
        end
    end

    // Compare every DUT output with the model in the middle of each cycle.
    always @(negedge clk) begin
        logic [70:0] eb;
        bit f;
        if (check_en) begin
            f = fires();
            if (mo < 0) eb = '0;
            else        eb = {cyc[mo], stb[mo] & ~mkill, we[mo], adr[mo], wdat[mo], sel[mo]};
            check("bus", {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel}, eb);
            check("gnt", gnt, (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00);
            check("to_evt", to_evt, f);
            for (int i = 0; i < 2; i++) begin
                check((i == 0) ? "m0_ret" : "m1_ret", {mack[i], merr[i], mdat[i]},
                      (mo == i) ? {s_ack, s_err | f, s_dat} : 34'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0;
            adr[i] = '0; wdat[i] = '0; sel[i] = '0;
        end
        s_dat = '0; s_ack = 0; s_err = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic random_phase(input int cycles, input int ack_div, input int drop_div, input bit stb_always);
        for (int c = 0; c < cycles; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!cyc[i]) cyc[i] = ($urandom_range(0, 3) == 0);
                else         cyc[i] = !($urandom_range(0, drop_div - 1) == 0);
                stb[i]  = cyc[i] && (stb_always || $urandom_range(0, 1) == 1);
                we[i]   = 1'($urandom);
                adr[i]  = $urandom;
                wdat[i] = $urandom;
                sel[i]  = 4'($urandom);
            end
            s_ack = ($urandom_range(0, ack_div - 1) == 0);
            s_err = ($urandom_range(0, 15) == 0) && !stb_always;
            s_dat = $urandom;
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        mo = -1; ml = 1; mrun = 0; mkill = 0;
        tick();
        check_en = 1;
        do_reset();

        // single master read
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h1000_0000; sel[0] = 4'hf;
        sample(); check("t1_gnt_pre", gnt, 2'b00);
        tick(); sample(); check("t1_gnt", gnt, 2'b01);
        check("t1_s_adr", s_adr, 32'h1000_0000);
        tick();
        tick(); s_ack = 1; s_dat = 32'hDEAD_BEEF;
        sample();
        check("t1_ack", mack[0], 1'b1);
        check("t1_dat", mdat[0], 32'hDEAD_BEEF);
        check("t1_m1_ack", mack[1], 1'b0);
        tick(); clear_inputs();
        tick();

        // tie after reset, idle gap, then alternation
        do_reset();
        tick(); cyc[0] = 1; cyc[1] = 1;
        tick(); sample(); check("t2_first", gnt, 2'b01);
        tick(); cyc[0] = 0; sample(); check("t2_hold", gnt, 2'b01);
        tick(); sample(); check("t2_gap", gnt, 2'b00);
        tick(); sample(); check("t2_second", gnt, 2'b10);
        tick(); cyc[1] = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            cyc[0] = 1; cyc[1] = 1;
            tick(); sample(); check("t2_rr", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick(); cyc[0] = 0; cyc[1] = 0;
            tick();
        end

        // lock: m1 keeps the bus through three back-to-back writes
        cyc[1] = 1; we[1] = 1; sel[1] = 4'h3;
        tick(); cyc[0] = 1; stb[1] = 1; s_ack = 1;
        for (int j = 0; j < 3; j++) begin
            adr[1] = 32'h2000_0000 + 32'(j * 4); wdat[1] = 32'hA5A5_0000 + 32'(j);
            sample();
            check("t3_gnt", gnt, 2'b10);
            check("t3_ack", {mack[1], mack[0]}, 2'b10);
            tick();
        end
        cyc[1] = 0; stb[1] = 0; s_ack = 0;
        sample(); check("t3_release", gnt, 2'b10);
        tick(); sample(); check("t3_gap", gnt, 2'b00);
        tick(); sample(); check("t3_m0", gnt, 2'b01);
        tick(); cyc[0] = 0;
        tick();

        // watchdog fires on the last stalled cycle
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h3000_0000;
        tick();
        repeat (C_TO - 2) tick();
        sample(); check("t4_pre_evt", {to_evt, merr[0]}, 2'b00);
        tick(); sample(); check("t4_evt", {to_evt, merr[0]}, 2'b11);
        tick(); sample(); check("t4_kill", {s_stb, merr[0], to_evt}, 3'b000);
        tick(); sample(); check("t4_restb", s_stb, 1'b1);
        tick(); clear_inputs();
        tick();

        // ack on the boundary cycle wins over the watchdog
        cyc[0] = 1; stb[0] = 1;
        tick();
        repeat (C_TO - 1) tick();
        s_ack = 1;
        sample(); check("t5_boundary", {mack[0], merr[0], to_evt}, 3'b100);
        tick(); clear_inputs();
        tick();

        // reset in the middle of an m1 write
        cyc[1] = 1; stb[1] = 1; we[1] = 1; s_ack = 1;
        tick(); rst = 1;
        sample(); check("t6_g1", gnt, 2'b10);
        tick(); rst = 0; cyc[0] = 1;
        sample(); check("t6_after_rst", {s_cyc, gnt}, 3'b000);
        tick(); sample(); check("t6_tie", gnt, 2'b01);
        tick(); clear_inputs();
        tick();

        // randomized traffic, then long stalls to exercise the watchdog
        random_phase(3000, 3, 6, 1'b0);
        random_phase(2500, 400, 1000, 1'b1);
        tick(); rst = 0; clear_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
